// File: rtl/rect_drawer_pkg.sv
// Shared types and constants for the rect_drawer slice: screen defaults,
// coordinate/colour widths, FSM state enum and the debug view struct.
package draw_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } draw_state_t;

  typedef struct packed {
    draw_state_t state;
    logic        off_screen;
  } draw_dbg_t;

endpackage

// File: rtl/rect_drawer_if.sv
// Request/pixel bundle between a rect_drawer client and the drawer.
// Handshake: start is sampled only while busy is low; once accepted, busy stays
// high until the cycle after the one-cycle done pulse, and plot qualifies x/y/colour.
interface rect_drawer_if;
  import draw_pkg::*;

  logic          start;
  logic [XW-1:0] rx;
  logic [YW-1:0] ry;
  logic [XW-1:0] rw;
  logic [YW-1:0] rh;
  logic [CW-1:0] rcolour;
  logic          busy;
  logic          done;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] colour;
  logic          plot;

  modport master (
    output start, rx, ry, rw, rh, rcolour,
    input  busy, done, x, y, colour, plot
  );

  modport slave (
    input  start, rx, ry, rw, rh, rcolour,
    output busy, done, x, y, colour, plot
  );

endinterface

// File: rtl/rect_drawer_raster_counter.sv
// Row-major dx/dy walker over a width x height box; presents the next position
// combinationally so the owner can register the following pixel in one cycle.
module raster_counter
  import draw_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  input  logic [XW-1:0] width,
  input  logic [YW-1:0] height,
  output logic [XW-1:0] next_dx,
  output logic [YW-1:0] next_dy,
  output logic          last
);

  logic [XW-1:0] dx;
  logic [YW-1:0] dy;
  logic          row_end;

  always_comb begin
    row_end = (dx == width - XW'(1));
    last    = row_end && (dy == height - YW'(1));
    next_dx = row_end ? '0 : dx + XW'(1);
    next_dy = row_end ? dy + YW'(1) : dy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx <= '0;
      dy <= '0;
    end else if (clear) begin
      dx <= '0;
      dy <= '0;
    end else if (advance) begin
      dx <= next_dx;
      dy <= next_dy;
    end
  end

endmodule

// File: rtl/rect_drawer.sv
// Filled-rectangle rasteriser feeding a VGA adapter one pixel per cycle.
// Define RECT_DRAWER_CLIP_EN to suppress plot for pixels beyond SCREEN_W/SCREEN_H.
module rect_drawer
  import draw_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          start,
  input  logic [XW-1:0] rx,
  input  logic [YW-1:0] ry,
  input  logic [XW-1:0] rw,
  input  logic [YW-1:0] rh,
  input  logic [CW-1:0] rcolour,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour,
  output logic          plot,
  output draw_dbg_t     dbg
);

  localparam logic [XW:0] X_LIM = SCREEN_W[XW:0];
  localparam logic [YW:0] Y_LIM = SCREEN_H[YW:0];

  draw_state_t   state;
  logic [XW-1:0] lrx, lrw;
  logic [YW-1:0] lry, lrh;
  logic [CW-1:0] lcol;
  logic          off_q;

  logic [XW-1:0] next_dx;
  logic [YW-1:0] next_dy;
  logic          last;
  logic          cnt_clear, cnt_advance;

  logic          accepting;
  logic [XW-1:0] base_x, step_x;
  logic [YW-1:0] base_y, step_y;
  logic [XW:0]   sum_x;
  logic [YW:0]   sum_y;
  logic          off_screen, pix_plot;

  raster_counter u_raster (
    .clk     (CLOCK_50),
    .rst_n   (resetn),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .width   (lrw),
    .height  (lrh),
    .next_dx (next_dx),
    .next_dy (next_dy),
    .last    (last)
  );

  // In IDLE the first pixel comes straight from the request inputs, because the
  // latches only capture them on the same edge that registers that pixel.
  always_comb begin
    accepting   = (state == S_IDLE);
    cnt_clear   = (state == S_IDLE);
    cnt_advance = (state == S_DRAW) && !last;
    base_x      = accepting ? rx : lrx;
    base_y      = accepting ? ry : lry;
    step_x      = accepting ? '0 : next_dx;
    step_y      = accepting ? '0 : next_dy;
    sum_x       = {1'b0, base_x} + {1'b0, step_x};
    sum_y       = {1'b0, base_y} + {1'b0, step_y};
    off_screen  = (sum_x >= X_LIM) || (sum_y >= Y_LIM);
`ifdef RECT_DRAWER_CLIP_EN
    pix_plot    = !off_screen;
`else
    pix_plot    = 1'b1;
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      off_q  <= 1'b0;
      lrx    <= '0;
      lry    <= '0;
      lrw    <= '0;
      lrh    <= '0;
      lcol   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          plot <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            lrx    <= rx;
            lry    <= ry;
            lrw    <= rw;
            lrh    <= rh;
            lcol   <= rcolour;
            colour <= rcolour;
            busy   <= 1'b1;
            if (rw == '0 || rh == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_DRAW;
              x     <= sum_x[XW-1:0];
              y     <= sum_y[YW-1:0];
              off_q <= off_screen;
              plot  <= pix_plot;
            end
          end
        end
        S_DRAW: begin
          if (last) begin
            state <= S_DONE;
            plot  <= 1'b0;
            done  <= 1'b1;
          end else begin
            x      <= sum_x[XW-1:0];
            y      <= sum_y[YW-1:0];
            colour <= lcol;
            off_q  <= off_screen;
            plot   <= pix_plot;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          plot  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          plot  <= 1'b0;
        end
      endcase
    end
  end

  assign dbg = {state, off_q};

endmodule
